// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter: read-owner FSM states,
// owner encoding and the default external-port starvation bound.
package dmem_arb_pkg;

  localparam int unsigned STARVE_MAX_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE,
    RD_CPU,
    RD_EXT
  } rd_state_e;

  typedef enum logic {
    OWN_CPU,
    OWN_EXT
  } owner_e;

endpackage

// File: rtl/starve_counter.sv
// Saturating wait counter for the external port; sat_o flags that the
// external requester has waited the full bound and must win next.
module starve_counter #(
  parameter int unsigned MaxCnt = 4,
  parameter int unsigned CntW   = (MaxCnt < 1) ? 1 : $clog2(MaxCnt + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign sat_o = (cnt_q == CntW'(MaxCnt));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !sat_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter sharing one single-cycle-latency SRAM between the CPU MEM stage
// and an external host, with starvation-bounded CPU priority and range checking.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              cpu_req,
  input  logic              cpu_wen,
  input  logic [31:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ext_req,
  input  logic              ext_wen,
  input  logic [31:0]       ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic              mem_ren,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              addr_err
);

  rd_state_e         state_q, state_d;
  logic              err_q, err_d;
  logic              starve_sat;
  logic              ext_pri;
  owner_e            owner;
  logic [31:0]       sel_addr;
  logic              sel_wen;
  logic              any_gnt;
  logic              oor;
  logic [DATA_W-1:0] rd_data;

  starve_counter #(
    .MaxCnt (STARVE_MAX)
  ) u_starve_counter (
    .clk_i (clk),
    .rst_i (rst),
    .inc_i (ext_req & ~ext_gnt),
    .clr_i (ext_gnt),
    .sat_o (starve_sat)
  );

  // Host wins contention while the CPU is halted or once it has waited long enough.
  assign ext_pri = ~enable | starve_sat;

  always_comb begin
    cpu_gnt = 1'b0;
    ext_gnt = 1'b0;
    if (!rst) begin
      if (cpu_req && ext_req) begin
        ext_gnt = ext_pri;
        cpu_gnt = ~ext_pri;
      end else begin
        cpu_gnt = cpu_req;
        ext_gnt = ext_req;
      end
    end
  end

  assign owner     = ext_gnt ? OWN_EXT : OWN_CPU;
  assign sel_addr  = (owner == OWN_EXT) ? ext_addr : cpu_addr;
  assign sel_wen   = (owner == OWN_EXT) ? ext_wen : cpu_wen;
  assign mem_wdata = (owner == OWN_EXT) ? ext_wdata : cpu_wdata;
  assign any_gnt   = cpu_gnt | ext_gnt;
  assign oor       = |sel_addr[31:ADDR_W];

  assign mem_addr  = sel_addr[ADDR_W-1:0];
  assign mem_wen   = any_gnt & sel_wen & ~oor;
  assign mem_ren   = any_gnt & ~sel_wen & ~oor;
  assign cpu_stall = cpu_req & ~cpu_gnt;

  always_comb begin
    state_d = IDLE;
    err_d   = any_gnt & oor;
    if (any_gnt && !sel_wen) begin
      state_d = (owner == OWN_EXT) ? RD_EXT : RD_CPU;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  // err_q belongs to the access that put the FSM in a read state, so it zeroes that data.
  assign rd_data    = err_q ? '0 : mem_rdata;
  assign addr_err   = err_q;
  assign cpu_rvalid = (state_q == RD_CPU) & ~rst;
  assign ext_rvalid = (state_q == RD_EXT) & ~rst;
  assign cpu_rdata  = cpu_rvalid ? rd_data : '0;
  assign ext_rdata  = ext_rvalid ? rd_data : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a per-cycle reference model plus
// directed scenarios with literal expectations.
module tb_dmem_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int SM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          cpu_req, cpu_wen;
  logic [31:0]   cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt, cpu_stall, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          ext_req, ext_wen;
  logic [31:0]   ext_addr;
  logic [DW-1:0] ext_wdata;
  logic          ext_gnt, ext_rvalid;
  logic [DW-1:0] ext_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_wen, mem_ren;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          addr_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .STARVE_MAX (SM)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .cpu_req    (cpu_req),
    .cpu_wen    (cpu_wen),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_stall  (cpu_stall),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .ext_req    (ext_req),
    .ext_wen    (ext_wen),
    .ext_addr   (ext_addr),
    .ext_wdata  (ext_wdata),
    .ext_gnt    (ext_gnt),
    .ext_rvalid (ext_rvalid),
    .ext_rdata  (ext_rdata),
    .mem_addr   (mem_addr),
    .mem_wen    (mem_wen),
    .mem_ren    (mem_ren),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .addr_err   (addr_err)
  );

  // SRAM environment with one-cycle read latency.
  logic [DW-1:0] sram [1024];
  bit            sram_ready = 1'b0;

  always @(posedge clk) begin
    if (!sram_ready) begin
      for (int i = 0; i < 1024; i++) sram[i] <= '0;
      sram[16]   <= 32'hDEADBEEF;
      sram_ready <= 1'b1;
    end else begin
      if (mem_wen) sram[mem_addr] <= mem_wdata;
      if (mem_ren) mem_rdata <= sram[mem_addr];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: memory contents, host wait count and the read owed next cycle.
  logic [31:0] mmem [1024];
  bit          model_ready = 1'b0;
  bit          model_on    = 1'b0;
  int          starve      = 0;
  bit          pend_cpu    = 1'b0;
  bit          pend_ext    = 1'b0;
  logic [31:0] pend_data   = '0;
  bit          m_err       = 1'b0;

  always @(negedge clk) begin
    bit          g_cpu, g_ext, g_any, w, out_rng;
    logic [31:0] a, wd;
    if (!model_ready) begin
      for (int i = 0; i < 1024; i++) mmem[i] = '0;
      mmem[16]    = 32'hDEADBEEF;
      model_ready = 1'b1;
    end
    if (model_on) begin
      g_cpu = 1'b0;
      g_ext = 1'b0;
      if (!rst) begin
        if (cpu_req && ext_req) begin
          if (!enable || starve >= SM) g_ext = 1'b1;
          else g_cpu = 1'b1;
        end else begin
          g_cpu = cpu_req;
          g_ext = ext_req;
        end
      end
      g_any   = g_cpu || g_ext;
      a       = g_ext ? ext_addr : cpu_addr;
      w       = g_ext ? ext_wen : cpu_wen;
      wd      = g_ext ? ext_wdata : cpu_wdata;
      out_rng = (a >> AW) != 0;

      check("m_cpu_gnt", 64'(cpu_gnt), 64'(g_cpu));
      check("m_ext_gnt", 64'(ext_gnt), 64'(g_ext));
      check("m_cpu_stall", 64'(cpu_stall), 64'(cpu_req && !g_cpu));
      check("m_mem_wen", 64'(mem_wen), 64'(g_any && w && !out_rng));
      check("m_mem_ren", 64'(mem_ren), 64'(g_any && !w && !out_rng));
      if (g_any) check("m_mem_addr", 64'(mem_addr), 64'(a % 1024));
      if (g_any && w) check("m_mem_wdata", 64'(mem_wdata), 64'(wd));
      check("m_cpu_rvalid", 64'(cpu_rvalid), 64'(pend_cpu && !rst));
      check("m_cpu_rdata", 64'(cpu_rdata), (pend_cpu && !rst) ? 64'(pend_data) : 64'd0);
      check("m_ext_rvalid", 64'(ext_rvalid), 64'(pend_ext && !rst));
      check("m_ext_rdata", 64'(ext_rdata), (pend_ext && !rst) ? 64'(pend_data) : 64'd0);
      check("m_addr_err", 64'(addr_err), 64'(m_err));

      if (rst) begin
        starve   = 0;
        pend_cpu = 1'b0;
        pend_ext = 1'b0;
        m_err    = 1'b0;
      end else begin
        m_err     = g_any && out_rng;
        pend_cpu  = g_cpu && !w;
        pend_ext  = g_ext && !w;
        pend_data = out_rng ? 32'd0 : mmem[a % 1024];
        if (g_any && w && !out_rng) mmem[a % 1024] = wd;
        if (g_ext) starve = 0;
        else if (ext_req && starve < SM) starve++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cpu(input bit req, input bit wen, input logic [31:0] addr,
                         input logic [31:0] wd);
    cpu_req   = req;
    cpu_wen   = wen;
    cpu_addr  = addr;
    cpu_wdata = wd;
  endtask

  task automatic set_ext(input bit req, input bit wen, input logic [31:0] addr,
                         input logic [31:0] wd);
    ext_req   = req;
    ext_wen   = wen;
    ext_addr  = addr;
    ext_wdata = wd;
  endtask

  logic [5:0] gv_cpu, gv_ext, gv_stall;

  initial begin
    rst    = 1'b1;
    enable = 1'b0;
    set_cpu(0, 0, 0, 0);
    set_ext(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    model_on = 1'b1;

    // Under reset nothing is granted and a CPU request stalls.
    set_cpu(1, 0, 32'h10, 0);
    @(negedge clk);
    check("rst_cpu_gnt", 64'(cpu_gnt), 64'd0);
    check("rst_cpu_stall", 64'(cpu_stall), 64'd1);
    check("rst_mem_ren", 64'(mem_ren), 64'd0);
    step();
    rst    = 1'b0;
    enable = 1'b1;
    set_cpu(0, 0, 0, 0);

    // Lone CPU read of 0x10.
    step();
    set_cpu(1, 0, 32'h10, 0);
    @(negedge clk);
    check("rd_cpu_gnt", 64'(cpu_gnt), 64'd1);
    check("rd_mem_ren", 64'(mem_ren), 64'd1);
    check("rd_mem_addr", 64'(mem_addr), 64'h10);
    step();
    set_cpu(0, 0, 0, 0);
    @(negedge clk);
    check("rd_cpu_rvalid", 64'(cpu_rvalid), 64'd1);
    check("rd_cpu_rdata", 64'(cpu_rdata), 64'hDEADBEEF);
    check("rd_ext_rvalid", 64'(ext_rvalid), 64'd0);
    check("rd_ext_rdata", 64'(ext_rdata), 64'd0);

    // Continuous contention: CPU for four cycles, then the starved host once.
    step();
    set_cpu(1, 0, 32'h10, 0);
    set_ext(1, 0, 32'h20, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      gv_cpu[i]   = cpu_gnt;
      gv_ext[i]   = ext_gnt;
      gv_stall[i] = cpu_stall;
      step();
      if (i == 4) ext_req = 1'b0;
    end
    set_cpu(0, 0, 0, 0);
    check("starve_cpu_gnt", 64'(gv_cpu), 64'b101111);
    check("starve_ext_gnt", 64'(gv_ext), 64'b010000);
    check("starve_stall", 64'(gv_stall), 64'b010000);

    // CPU halted: host write then read of the top word.
    step();
    enable = 1'b0;
    set_ext(1, 1, 32'h3FF, 32'h55);
    @(negedge clk);
    check("hw_ext_gnt", 64'(ext_gnt), 64'd1);
    check("hw_mem_wen", 64'(mem_wen), 64'd1);
    step();
    set_ext(1, 0, 32'h3FF, 0);
    @(negedge clk);
    check("hr_ext_gnt", 64'(ext_gnt), 64'd1);
    check("hw_no_rvalid", 64'(ext_rvalid), 64'd0);
    step();
    set_ext(0, 0, 0, 0);
    @(negedge clk);
    check("hr_ext_rvalid", 64'(ext_rvalid), 64'd1);
    check("hr_ext_rdata", 64'(ext_rdata), 64'h55);

    // CPU halted under contention: host wins, CPU stalls.
    step();
    set_cpu(1, 0, 32'h10, 0);
    set_ext(1, 0, 32'h20, 0);
    @(negedge clk);
    check("halt_ext_gnt", 64'(ext_gnt), 64'd1);
    check("halt_cpu_stall", 64'(cpu_stall), 64'd1);
    step();
    set_ext(0, 0, 0, 0);
    @(negedge clk);
    check("halt_cpu_gnt", 64'(cpu_gnt), 64'd1);
    step();
    set_cpu(0, 0, 0, 0);

    // Out-of-range CPU read.
    step();
    enable = 1'b1;
    set_cpu(1, 0, 32'h400, 0);
    @(negedge clk);
    check("oor_cpu_gnt", 64'(cpu_gnt), 64'd1);
    check("oor_mem_ren", 64'(mem_ren), 64'd0);
    step();
    set_cpu(0, 0, 0, 0);
    @(negedge clk);
    check("oor_addr_err", 64'(addr_err), 64'd1);
    check("oor_cpu_rvalid", 64'(cpu_rvalid), 64'd1);
    check("oor_cpu_rdata", 64'(cpu_rdata), 64'd0);
    step();
    @(negedge clk);
    check("oor_err_pulse", 64'(addr_err), 64'd0);

    // Read-after-write, then alternating read owners with no bubble.
    step();
    set_cpu(1, 1, 32'h20, 32'h12345678);
    @(negedge clk);
    check("raw_mem_wen", 64'(mem_wen), 64'd1);
    step();
    set_cpu(1, 0, 32'h20, 0);
    @(negedge clk);
    check("raw_wr_no_rvalid", 64'(cpu_rvalid), 64'd0);
    step();
    set_cpu(0, 0, 0, 0);
    set_ext(1, 0, 32'h3FF, 0);
    @(negedge clk);
    check("raw_cpu_rdata", 64'(cpu_rdata), 64'h12345678);
    check("alt1_ext_rvalid", 64'(ext_rvalid), 64'd0);
    step();
    set_ext(0, 0, 0, 0);
    set_cpu(1, 0, 32'h10, 0);
    @(negedge clk);
    check("alt2_ext_rdata", 64'(ext_rdata), 64'h55);
    check("alt2_cpu_rvalid", 64'(cpu_rvalid), 64'd0);
    step();
    set_cpu(0, 0, 0, 0);
    @(negedge clk);
    check("alt3_cpu_rdata", 64'(cpu_rdata), 64'hDEADBEEF);

    // Reset while a CPU read is in flight drops it.
    step();
    set_cpu(1, 0, 32'h10, 0);
    @(negedge clk);
    check("fl_cpu_gnt", 64'(cpu_gnt), 64'd1);
    step();
    set_cpu(0, 0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    check("fl_rst_rvalid", 64'(cpu_rvalid), 64'd0);
    check("fl_rst_rdata", 64'(cpu_rdata), 64'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("fl_post_rvalid", 64'(cpu_rvalid), 64'd0);
    check("fl_post_err", 64'(addr_err), 64'd0);
    step();
    set_cpu(1, 0, 32'h10, 0);
    @(negedge clk);
    check("fl_re_gnt", 64'(cpu_gnt), 64'd1);
    step();
    set_cpu(0, 0, 0, 0);
    @(negedge clk);
    check("fl_re_rdata", 64'(cpu_rdata), 64'hDEADBEEF);

    // Out-of-range host write is suppressed but flagged.
    step();
    set_ext(1, 1, 32'h800, 32'hAA);
    @(negedge clk);
    check("oorw_ext_gnt", 64'(ext_gnt), 64'd1);
    check("oorw_mem_wen", 64'(mem_wen), 64'd0);
    step();
    set_ext(0, 0, 0, 0);
    @(negedge clk);
    check("oorw_addr_err", 64'(addr_err), 64'd1);
    check("oorw_no_rvalid", 64'(ext_rvalid), 64'd0);

    step();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, default 10, data-memory word-address width; DATA_W, default 32, data width; STARVE_MAX, default 4, maximum cycles the external port waits while the CPU holds the memory.
REQ-002 SHALL use one clock, clk; reset rst is synchronous and active-high.
REQ-003 SHALL have ports (name  direction  width  meaning), clock and reset first:
- clk  in  1  clock
- rst  in  1  reset
- enable  in  1  CPU running
- cpu_req  in  1  CPU MEM-stage access request
- cpu_wen  in  1  CPU request is a write
- cpu_addr  in  32  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  CPU request accepted this cycle
- cpu_stall  out  1  hold CPU pipeline
- cpu_rvalid  out  1  CPU read data valid
- cpu_rdata  out  DATA_W  CPU read data
- ext_req  in  1  host access request
- ext_wen  in  1  host request is a write
- ext_addr  in  32  host address
- ext_wdata  in  DATA_W  host write data
- ext_gnt  out  1  host request accepted
- ext_rvalid  out  1  host read data valid
- ext_rdata  out  DATA_W  host read data
- mem_addr  out  ADDR_W  SRAM address
- mem_wen  out  1  SRAM write enable
- mem_ren  out  1  SRAM read enable
- mem_wdata  out  DATA_W  SRAM write data
- mem_rdata  in  DATA_W  SRAM read data (1-cycle latency)
- addr_err  out  1  registered pulse: granted access was out of range

Function
REQ-004 SHALL issue at most one SRAM access per cycle. The grant is combinational and is made in the same cycle the mem_* command is driven.
REQ-005 A requester SHALL hold req, wen, addr and wdata stable until it sees gnt. A request that is not granted has no side effect.
REQ-006 Arbitration SHALL be:
- enable=0: ext wins.
- enable=1 and starve_cnt==STARVE_MAX: ext wins.
- otherwise: cpu wins.
- A lone requester always wins.
REQ-007 starve_cnt SHALL:
- increment each cycle with ext_req=1 and ext_gnt=0;
- saturate at STARVE_MAX;
- clear on ext_gnt.
REQ-008 cpu_stall SHALL equal cpu_req & ~cpu_gnt.
REQ-009 mem_addr SHALL equal addr[ADDR_W-1:0] of the granted requester. mem_wen=gnt&wen; mem_ren=gnt&~wen.
REQ-010 If addr[31:ADDR_W] is nonzero on a granted access:
- mem_wen and mem_ren SHALL be 0;
- addr_err SHALL pulse for one cycle in the next cycle;
- a read SHALL still produce rvalid, with rdata=0.
REQ-011 Read-owner FSM:
- States: IDLE, RD_CPU, RD_EXT.
- Next state: RD_CPU after a granted CPU read; RD_EXT after a granted ext read; IDLE otherwise.
REQ-012 Read data return:
- In RD_CPU: cpu_rvalid=1 and cpu_rdata=mem_rdata (0 if out of range).
- In RD_EXT: ext_rvalid and ext_rdata likewise.
- Otherwise both rvalid outputs are 0 and both rdata outputs are 0.
REQ-013 Back-to-back grants to alternating owners SHALL route each rvalid to the correct requester with no bubble.
REQ-014 Writes SHALL produce no rvalid. A read to the address written in the previous cycle SHALL return the new data.

Reset
REQ-015 rst SHALL set, on the next clk edge: FSM to IDLE, starve_cnt to 0, addr_err to 0, both rvalid to 0, both rdata to 0.
REQ-016 While rst=1, all gnt, mem_wen and mem_ren outputs SHALL be 0, and cpu_stall SHALL equal cpu_req.
REQ-017 A read in flight when rst asserts SHALL be dropped, with no rvalid.

Structure
REQ-018 Shared package dmem_arb_pkg SHALL hold:
- the FSM state enum (IDLE, RD_CPU, RD_EXT);
- the default STARVE_MAX;
- the owner encoding (OWN_CPU, OWN_EXT).
REQ-019 One sub-module, starve_counter, SHALL implement the saturating counter of REQ-007, with a width sufficient for STARVE_MAX.

Verification
REQ-020 enable=1, cpu read addr 0x10 only, SRAM[0x10]=0xDEADBEEF -> cpu_gnt same cycle; cpu_rvalid=1 with cpu_rdata=0xDEADBEEF next cycle; ext outputs 0.
REQ-021 enable=1, cpu_req and ext_req held high continuously, STARVE_MAX=4 -> cpu granted cycles 0-3, ext granted cycle 4, starve_cnt back to 0, cpu_stall=1 only in cycle 4.
REQ-022 enable=0, ext write 0x55 to 0x3FF then ext read 0x3FF -> ext_gnt both cycles; ext_rvalid with 0x55 one cycle after the read.
REQ-023 cpu read 0x400 (out of range) -> mem_ren=0; addr_err=1 and cpu_rvalid=1 with cpu_rdata=0 next cycle.
REQ-024 cpu read granted, rst=1 the next cycle -> cpu_rvalid=0; all state cleared; a cpu read after rst deasserts behaves as in REQ-020.
